// File: rtl/commutate_pkg.sv
// Shared types and constants for the six-step commutation PWM block.
// Phase indices are U=0, V=1, W=2; hall bits arrive as {U,V,W}.
package commutate_pkg;

  localparam int PWM_W = 11;
  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, BRAKE, FAULT} state_e;
  typedef enum logic [1:0] {PH_U = 2'd0, PH_V = 2'd1, PH_W = 2'd2, PH_NONE = 2'd3} phase_e;

  typedef struct packed {
    phase_e pwm_ph;
    phase_e low_ph;
  } comm_t;

  localparam comm_t COMM_101  = '{pwm_ph: PH_U, low_ph: PH_V};
  localparam comm_t COMM_100  = '{pwm_ph: PH_U, low_ph: PH_W};
  localparam comm_t COMM_110  = '{pwm_ph: PH_V, low_ph: PH_W};
  localparam comm_t COMM_010  = '{pwm_ph: PH_V, low_ph: PH_U};
  localparam comm_t COMM_011  = '{pwm_ph: PH_W, low_ph: PH_U};
  localparam comm_t COMM_001  = '{pwm_ph: PH_W, low_ph: PH_V};
  localparam comm_t COMM_NONE = '{pwm_ph: PH_NONE, low_ph: PH_NONE};

  function automatic logic hall_valid(input logic [2:0] h);
    return (h != 3'b000) && (h != 3'b111);
  endfunction

  function automatic comm_t comm_decode(input logic [2:0] h);
    comm_t row;
    case (h)
      3'b101:  row = COMM_101;
      3'b100:  row = COMM_100;
      3'b110:  row = COMM_110;
      3'b010:  row = COMM_010;
      3'b011:  row = COMM_011;
      3'b001:  row = COMM_001;
      default: row = COMM_NONE;
    endcase
    return row;
  endfunction

endpackage

// File: rtl/commutate_pwm_core.sv
// Free-running PWM counter with a duty shadow register that only reloads at wrap,
// so a duty write never reshapes the period already in progress.
module pwm_core
  import commutate_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] duty_i,
  output logic             pwm_o,
  output logic             period_start_o
);

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] duty_sh_q, duty_sh_d;

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    duty_sh_d = (cnt_q == CNT_MAX) ? duty_i : duty_sh_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      duty_sh_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      duty_sh_q <= duty_sh_d;
    end
  end

  assign pwm_o          = (cnt_q < duty_sh_q);
  assign period_start_o = (cnt_q == '0);

endmodule

// File: rtl/commutate_pwm.sv
// BLDC six-step commutation: hall synchroniser, IDLE/RUN/BRAKE/FAULT control and
// registered raw gate commands. Dead time is added downstream.
module commutate_pwm
  import commutate_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] duty,
  input  logic [2:0]       hall,
  input  logic             drv_en,
  input  logic             brake,
  output logic             highU,
  output logic             lowU,
  output logic             highV,
  output logic             lowV,
  output logic             highW,
  output logic             lowW,
  output logic             pwm_sync,
  output logic             hall_err
);

  logic       pwm, period_start;
  logic [2:0] sync1_q, hall_s;
  state_e     state_q, state_d;
  logic [2:0] hi_q, lo_q, hi_d, lo_d;
  logic       sync_q, err_q;
  logic       hall_ok, run_row;
  comm_t      row;

  pwm_core u_pwm_core (
    .clk            (clk),
    .rst            (rst),
    .duty_i         (duty),
    .pwm_o          (pwm),
    .period_start_o (period_start)
  );

  assign hall_ok = hall_valid(hall_s);
  assign row     = comm_decode(hall_s);

  // Brake outranks a hall fault, which outranks a plain disable.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (brake)       state_d = BRAKE;
        else if (drv_en) state_d = hall_ok ? RUN : FAULT;
      end
      RUN: begin
        if (brake)         state_d = BRAKE;
        else if (!hall_ok) state_d = FAULT;
        else if (!drv_en)  state_d = IDLE;
      end
      BRAKE: begin
        if (!brake) state_d = IDLE;
      end
      FAULT: begin
        if (brake)                   state_d = BRAKE;
        else if (hall_ok || !drv_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Invalid hall codes decode to no phase, so a RUN cycle that sees a fault is all-off.
  assign run_row = (state_q == RUN) && hall_ok;

  for (genvar gi = 0; gi < 3; gi++) begin : g_phase
    assign hi_d[gi] = run_row && (row.pwm_ph == phase_e'(gi)) && pwm;
    assign lo_d[gi] = (state_q == BRAKE) ? pwm
                    : run_row && (((row.pwm_ph == phase_e'(gi)) && !pwm) ||
                                  (row.low_ph == phase_e'(gi)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      hall_s  <= '0;
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      sync_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= hall;
      hall_s  <= sync1_q;
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sync_q  <= period_start;
      err_q   <= (state_q == FAULT);
    end
  end

  assign highU    = hi_q[0];
  assign lowU     = lo_q[0];
  assign highV    = hi_q[1];
  assign lowV     = lo_q[1];
  assign highW    = hi_q[2];
  assign lowW     = lo_q[2];
  assign pwm_sync = sync_q;
  assign hall_err = err_q;

endmodule

// File: tb/tb_commutate_pwm.sv
// Directed bench for commutate_pwm: reset, RUN PWM counts, duty shadowing,
// hall stepping, fault, brake, duty bounds and mid-period reset.
module tb_commutate_pwm;
  import commutate_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [PWM_W-1:0] duty;
  logic [2:0]       hall;
  logic             drv_en, brake;
  logic             highU, lowU, highV, lowV, highW, lowW, pwm_sync, hall_err;

  logic [2:0] hi_v, lo_v;
  assign hi_v = {highW, highV, highU};
  assign lo_v = {lowW, lowV, lowU};

  int checks   = 0;
  int failures = 0;
  int hi_n[3];
  int lo_n[3];
  int ovl_n, sync_n;
  bit sync_found;

  // Hand-written commutation table: hall code, PWM phase, low-on phase (U=0,V=1,W=2).
  logic [2:0] rows[6]   = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  int         pwm_ph[6] = '{0, 0, 1, 1, 2, 2};
  int         low_ph[6] = '{1, 2, 2, 0, 0, 1};

  always #5 clk = ~clk;

  commutate_pwm dut (
    .clk      (clk),
    .rst      (rst),
    .duty     (duty),
    .hall     (hall),
    .drv_en   (drv_en),
    .brake    (brake),
    .highU    (highU),
    .lowU     (lowU),
    .highV    (highV),
    .lowV     (lowV),
    .highW    (highW),
    .lowW     (lowW),
    .pwm_sync (pwm_sync),
    .hall_err (hall_err)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // True when the current outputs show the static shape of table row idx.
  function automatic bit row_ok(input int idx);
    bit ok = 1'b1;
    for (int p = 0; p < 3; p++) begin
      if (p == low_ph[idx])      ok &= (hi_v[p] == 1'b0) && (lo_v[p] == 1'b1);
      else if (p == pwm_ph[idx]) ok &= (hi_v[p] ^ lo_v[p]);
      else                       ok &= (hi_v[p] == 1'b0) && (lo_v[p] == 1'b0);
    end
    return ok;
  endfunction

  // Waits for the next period start, then tallies one full 2048-cycle period.
  task automatic measure(input int chg_at, input logic [PWM_W-1:0] chg_duty);
    int guard = 0;
    @(negedge clk);
    while (!pwm_sync && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    sync_found = pwm_sync;
    for (int p = 0; p < 3; p++) begin
      hi_n[p] = 0;
      lo_n[p] = 0;
    end
    ovl_n  = 0;
    sync_n = 0;
    for (int i = 0; i < 2048; i++) begin
      if (i > 0) @(negedge clk);
      if (i == chg_at) duty = chg_duty;
      for (int p = 0; p < 3; p++) begin
        hi_n[p] += int'(hi_v[p]);
        lo_n[p] += int'(lo_v[p]);
      end
      if ((hi_v & lo_v) != 3'b000) ovl_n++;
      sync_n += int'(pwm_sync);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; duty = 11'd512; hall = 3'b101; drv_en = 1'b0; brake = 1'b0;
    cyc(3);
    checks++;
    if ({hi_v, lo_v, pwm_sync, hall_err} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=00000000", {hi_v, lo_v, pwm_sync, hall_err});
    end
    rst = 1'b0;
    cyc(1);
    checks++;
    if (pwm_sync !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_sync got=%b want=1", pwm_sync);
    end
    $display("test_reset done");
  endtask

  task automatic test_run;
    cyc(3);
    drv_en = 1'b1;
    cyc(1);
    checks++;
    if (lowV !== 1'b0) begin
      failures++;
      $display("FAIL run_latency_early lowV got=%b want=0", lowV);
    end
    cyc(1);
    checks++;
    if ({highU, lowU, highV, lowV, highW, lowW} !== 6'b010100) begin
      failures++;
      $display("FAIL run_entry_duty0 got=%b want=010100", {highU, lowU, highV, lowV, highW, lowW});
    end
    measure(-1, 11'd0);
    checks++;
    if (!sync_found || hi_n[0] != 512 || lo_n[0] != 1536 || lo_n[1] != 2048 ||
        hi_n[1] != 0 || hi_n[2] + lo_n[2] != 0 || ovl_n != 0 || sync_n != 1) begin
      failures++;
      $display("FAIL run_period512 sync=%0d hiU=%0d loU=%0d loV=%0d hiV=%0d W=%0d ovl=%0d syncs=%0d want sync=1 512 1536 2048 0 0 0 1",
               sync_found, hi_n[0], lo_n[0], lo_n[1], hi_n[1], hi_n[2] + lo_n[2], ovl_n, sync_n);
    end
    measure(1000, 11'd1536);
    checks++;
    if (!sync_found || hi_n[0] != 512 || lo_n[0] != 1536) begin
      failures++;
      $display("FAIL duty_midperiod_hold sync=%0d hiU=%0d loU=%0d want 1 512 1536", sync_found, hi_n[0], lo_n[0]);
    end
    measure(-1, 11'd0);
    checks++;
    if (!sync_found || hi_n[0] != 1536 || lo_n[0] != 512) begin
      failures++;
      $display("FAIL duty_next_period sync=%0d hiU=%0d loU=%0d want 1 1536 512", sync_found, hi_n[0], lo_n[0]);
    end
    $display("test_run done");
  endtask

  task automatic test_hall_step;
    for (int k = 1; k <= 6; k++) begin
      int idx  = k % 6;
      int prev = k - 1;
      hall = rows[idx];
      for (int c = 1; c <= 4; c++) begin
        cyc(1);
        checks++;
        if ((hi_v & lo_v) !== 3'b000) begin
          failures++;
          $display("FAIL hall_overlap row=%b cyc=%0d hi=%b lo=%b", rows[idx], c, hi_v, lo_v);
        end
        if (c == 2) begin
          checks++;
          if (row_ok(prev) !== 1'b1) begin
            failures++;
            $display("FAIL hall_old_row row=%b hi=%b lo=%b want row %b", rows[idx], hi_v, lo_v, rows[prev]);
          end
        end
        if (c == 3) begin
          checks++;
          if (row_ok(idx) !== 1'b1) begin
            failures++;
            $display("FAIL hall_new_row row=%b hi=%b lo=%b", rows[idx], hi_v, lo_v);
          end
        end
      end
      $display("hall step %b checked", rows[idx]);
    end
  endtask

  task automatic test_fault;
    hall = 3'b111;
    cyc(3);
    checks++;
    if (hall_err !== 1'b0) begin
      failures++;
      $display("FAIL fault_early hall_err got=%b want=0", hall_err);
    end
    cyc(1);
    checks++;
    if ({hi_v, lo_v, hall_err} !== 7'b0000001) begin
      failures++;
      $display("FAIL fault_state got=%b want=0000001", {hi_v, lo_v, hall_err});
    end
    hall = 3'b001;
    cyc(4);
    checks++;
    if ({lowV, hall_err} !== 2'b00) begin
      failures++;
      $display("FAIL fault_idle lowV,hall_err got=%b want=00", {lowV, hall_err});
    end
    cyc(1);
    checks++;
    if ({lowV, highU, lowU, hall_err} !== 4'b1000) begin
      failures++;
      $display("FAIL fault_rerun lowV,highU,lowU,hall_err got=%b want=1000", {lowV, highU, lowU, hall_err});
    end
    $display("test_fault done");
  endtask

  task automatic test_duty_bounds;
    hall = 3'b101;
    duty = 11'd0;
    cyc(4);
    measure(-1, 11'd0);
    checks++;
    if (!sync_found || hi_n[0] != 0 || lo_n[0] != 2048 || lo_n[1] != 2048) begin
      failures++;
      $display("FAIL duty_zero sync=%0d hiU=%0d loU=%0d loV=%0d want 1 0 2048 2048", sync_found, hi_n[0], lo_n[0], lo_n[1]);
    end
    duty = 11'd2047;
    cyc(4);
    measure(-1, 11'd0);
    checks++;
    if (!sync_found || hi_n[0] != 2047 || lo_n[0] != 1 || ovl_n != 0) begin
      failures++;
      $display("FAIL duty_max sync=%0d hiU=%0d loU=%0d ovl=%0d want 1 2047 1 0", sync_found, hi_n[0], lo_n[0], ovl_n);
    end
    $display("test_duty_bounds done");
  endtask

  task automatic test_brake;
    duty  = 11'd1024;
    brake = 1'b1;
    cyc(4);
    measure(-1, 11'd0);
    checks++;
    if (!sync_found || hi_n[0] + hi_n[1] + hi_n[2] != 0 ||
        lo_n[0] != 1024 || lo_n[1] != 1024 || lo_n[2] != 1024 || hall_err !== 1'b0) begin
      failures++;
      $display("FAIL brake_pwm sync=%0d highs=%0d lo=%0d/%0d/%0d err=%b want 1 0 1024/1024/1024 0",
               sync_found, hi_n[0] + hi_n[1] + hi_n[2], lo_n[0], lo_n[1], lo_n[2], hall_err);
    end
    brake = 1'b0;
    cyc(2);
    checks++;
    if ({hi_v, lo_v} !== 6'b000000) begin
      failures++;
      $display("FAIL brake_release_idle got=%b want=000000", {hi_v, lo_v});
    end
    cyc(1);
    checks++;
    if (lowV !== 1'b1) begin
      failures++;
      $display("FAIL brake_release_rerun lowV got=%b want=1", lowV);
    end
    // Brake and hall fault reach the state machine in the same cycle.
    hall = 3'b111;
    cyc(2);
    brake = 1'b1;
    cyc(4);
    checks++;
    if ({hall_err, hi_v} !== 4'b0000) begin
      failures++;
      $display("FAIL brake_over_fault hall_err,hi got=%b want=0000", {hall_err, hi_v});
    end
    brake = 1'b0;
    cyc(3);
    checks++;
    if (hall_err !== 1'b1) begin
      failures++;
      $display("FAIL brake_then_fault hall_err got=%b want=1", hall_err);
    end
    hall = 3'b101;
    cyc(6);
    $display("test_brake done");
  endtask

  task automatic test_reset_mid;
    int guard = 0;
    while (highU !== 1'b1 && guard < 3000) begin
      cyc(1);
      guard++;
    end
    checks++;
    if (highU !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_precond highU got=%b want=1", highU);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({hi_v, lo_v, pwm_sync, hall_err} !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_async got=%b want=00000000", {hi_v, lo_v, pwm_sync, hall_err});
    end
    cyc(1);
    rst = 1'b0;
    cyc(1);
    checks++;
    if (pwm_sync !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_cnt0 pwm_sync got=%b want=1", pwm_sync);
    end
    cyc(1);
    checks++;
    if (pwm_sync !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_cnt1 pwm_sync got=%b want=0", pwm_sync);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_run();
    test_hall_step();
    test_fault();
    test_duty_bounds();
    test_brake();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/commutate_pwm.md
# commutate_pwm

Generates the six raw gate-drive commands (high/low per phase U, V, W) for the BLDC inverter from an 11-bit duty word and the 3-bit hall state. Sits upstream of the per-phase dead-time inserters: each highX/lowX pair feeds one non-overlap stage, which adds the dead time. This block guarantees commutation, PWM and brake behaviour only; dead time is not its job.

## Interface
- PWM_W, 11, width of PWM counter and duty word
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- duty  in  PWM_W  requested duty; sampled into shadow register at period wrap
- hall  in  3  raw hall sensor bits {hallU,hallV,hallW}, asynchronous to clk
- drv_en  in  1  enable motor drive
- brake  in  1  regenerative brake request; overrides drive
- highU/lowU, highV/lowV, highW/lowW  out  1 each  raw gate commands to non-overlap stages
- pwm_sync  out  1  one-cycle pulse on first cycle of each PWM period
- hall_err  out  1  high while FAULT state is active

## Operation
- PWM core: free-running PWM_W-bit counter cnt, wraps 2047->0. duty_sh loads duty when cnt==2047. pwm = (cnt < duty_sh). duty 0 -> pwm never high; duty 2047 -> high 2047 of 2048 cycles.
- Hall path: two-flop synchronizer, then hall_s. Commutation decoded from hall_s.
- Commutation table (hall_s -> PWM phase / low-on phase): 101 U/V, 100 U/W, 110 V/W, 010 V/U, 011 W/U, 001 W/V. Third phase: both high and low 0.
- RUN drive: PWM phase high = pwm, its low = ~pwm (complementary); low-on phase low = 1, high = 0.
- State machine (IDLE, RUN, BRAKE, FAULT):
  - IDLE: all outputs 0. -> BRAKE if brake; else -> RUN if drv_en and hall_s valid; else -> FAULT if drv_en and hall_s invalid.
  - RUN: table drive. -> FAULT if hall_s 000/111; -> BRAKE if brake; -> IDLE if !drv_en.
  - BRAKE: all highs 0, all lows = pwm (duty_sh sets brake strength). -> IDLE when !brake. Brake has priority over FAULT.
  - FAULT: all outputs 0, hall_err=1. -> IDLE when hall_s valid or !drv_en; brake -> BRAKE.
- Priority on simultaneous conditions: brake > fault > !drv_en.
- Hall change in RUN: new table row applies from next output register update; no wait for period boundary.

## Timing
- Reset: cnt=0, duty_sh=0, synchronizer=000, state=IDLE, all gate outputs 0, pwm_sync 0, hall_err 0. Reset mid-period forces outputs 0 in same edge-free (async) fashion.
- Gate outputs, pwm_sync, hall_err registered; one clk after the state/cnt that produced them.
- pwm_sync asserts on the cycle gate outputs reflect cnt==0.
- Hall pin to output: 3 clk (2 sync + 1 output register) plus state update, 4 clk worst case.
- duty change takes effect on first period after next wrap; never mid-period (no glitch pulses).
- Never highX=1 and lowX=1 simultaneously in any state, including transition cycles.

## Structure
- Package commutate_pkg: PWM_W, state enum (IDLE, RUN, BRAKE, FAULT), commutation table constants, hall_valid function.
- Sub-module pwm_core: counter, duty shadow register, compare, pwm_sync generation.
- Top: synchronizer, state machine, output mux/registers.

## Test plan
- Reset then drv_en=1, hall=101, duty=512 -> after 4 clk RUN; highU high 512/2048 cycles, lowU complement, lowV=1, W pair 0.
- duty 512->1536 written at cnt=1000 -> current period keeps 512-cycle high; next period 1536.
- Step hall through 101,100,110,010,011,001 -> each table row driven within 4 clk; no cycle with highX&lowX.
- hall=111 in RUN -> FAULT, all outputs 0, hall_err=1; hall=001 -> IDLE then RUN.
- brake=1 with duty=1024 in RUN -> all highs 0, all lows toggle 1024/2048; brake=0 -> IDLE.
- rst asserted mid-period with highU=1 -> all outputs 0 immediately, cnt=0 after release.
